warp_launch_ctrl: RTL

- Thread-manager sequencer that launches a kernel onto the 8-warp fetch/decode pipeline.
- Writes a starting PC into each requested warp's PC register over the WarpID_TM_PC / UpdatePC_TM_PC / StartingPC_TM_PC interface, one warp per cycle.
- Tracks live warps by watching decoded Exit instructions from both decode lanes, and reports kernel completion to the host.

---
 rtl/warp_launch_pkg.sv | 15 +
 rtl/active_mask_tracker.sv | 29 ++
 rtl/warp_launch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/warp_launch_pkg.sv
// Shared types and sizing constants for the warp launch controller.
package warp_launch_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WARP_ID_W = 3;
    localparam int NUMW_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/active_mask_tracker.sv
// Live-warp bitmap: one set port (warp ID) and two clear ports (decode lanes); set beats clear.
module active_mask_tracker
    import warp_launch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [WARP_ID_W-1:0] set_id,
    input  logic [NUM_WARPS-1:0] clr0,
    input  logic [NUM_WARPS-1:0] clr1,
    output logic [NUM_WARPS-1:0] mask,
    output logic                 all_zero
);

    logic [NUM_WARPS-1:0] set_oh;

    assign set_oh   = set_en ? (NUM_WARPS'(1) << set_id) : '0;
    assign all_zero = (mask == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else begin
            mask <= (mask & ~(clr0 | clr1)) | set_oh;
        end
    end

endmodule

// File: rtl/warp_launch_ctrl.sv
// Kernel launcher: strobes a starting PC into each requested warp, then waits for all warps to exit.
// Optional RUN-phase watchdog enabled by defining WARP_LAUNCH_WATCHDOG_EN.
module warp_launch_ctrl
    import warp_launch_pkg::*;
#(
    parameter int NUM_WARPS   = 8,
    parameter int PC_W        = 32,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start_Host_TM,
    input  logic [NUMW_W-1:0]    NumWarps_Host_TM,
    input  logic [PC_W-1:0]      StartingPC_Host_TM,
    input  logic [NUM_WARPS-1:0] Valid_ID0_TM,
    input  logic [NUM_WARPS-1:0] Valid_ID1_TM,
    input  logic                 Exit_ID0_TM,
    input  logic                 Exit_ID1_TM,
    output logic [WARP_ID_W-1:0] WarpID_TM_PC,
    output logic                 UpdatePC_TM_PC,
    output logic [PC_W-1:0]      StartingPC_TM_PC,
    output logic [NUM_WARPS-1:0] ActiveMask_TM,
    output logic                 Busy_TM_Host,
    output logic                 Done_TM_Host,
    output logic                 Err_TM_Host,
    output logic                 Timeout_TM_Host
);

    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_wdog
        $error("WDOG_CYCLES must fit the 16-bit watchdog counter");
    end

    state_e               state;
    logic [WARP_ID_W-1:0] counter;
    logic [NUMW_W-1:0]    num_warps_q;
    logic [NUMW_W-1:0]    last_idx;
    logic [PC_W-1:0]      pc_q;
    logic                 start_legal, accept, last_warp, tracking, wdog_fire;
    logic                 set_en, mask_zero;
    logic [WARP_ID_W-1:0] set_id;
    logic [NUM_WARPS-1:0] clr0, clr1;

    assign start_legal = (NumWarps_Host_TM != '0) && (NumWarps_Host_TM <= NUMW_W'(NUM_WARPS));
    assign accept      = (state == IDLE) && Start_Host_TM && start_legal;
    assign last_idx    = num_warps_q - NUMW_W'(1);
    assign last_warp   = (NUMW_W'(counter) == last_idx);
    assign tracking    = (state == LAUNCH) || (state == RUN);

    // Warp 0 is set on the accepting edge so its bit appears alongside its first strobe.
    assign set_en = accept || ((state == LAUNCH) && !last_warp);
    assign set_id = (state == LAUNCH) ? counter + WARP_ID_W'(1) : '0;
    assign clr0   = wdog_fire ? '1 :
                    (tracking ? (Valid_ID0_TM & {NUM_WARPS{Exit_ID0_TM}}) : '0);
    assign clr1   = tracking ? (Valid_ID1_TM & {NUM_WARPS{Exit_ID1_TM}}) : '0;

    active_mask_tracker u_mask (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_id   (set_id),
        .clr0     (clr0),
        .clr1     (clr1),
        .mask     (ActiveMask_TM),
        .all_zero (mask_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            counter          <= '0;
            num_warps_q      <= '0;
            pc_q             <= '0;
            WarpID_TM_PC     <= '0;
            UpdatePC_TM_PC   <= 1'b0;
            StartingPC_TM_PC <= '0;
            Busy_TM_Host     <= 1'b0;
            Done_TM_Host     <= 1'b0;
            Err_TM_Host      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here, so each branch only names the cycles they fire.
            UpdatePC_TM_PC <= 1'b0;
            Done_TM_Host   <= 1'b0;
            Err_TM_Host    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        num_warps_q      <= NumWarps_Host_TM;
                        pc_q             <= StartingPC_Host_TM;
                        counter          <= '0;
                        WarpID_TM_PC     <= '0;
                        StartingPC_TM_PC <= StartingPC_Host_TM;
                        UpdatePC_TM_PC   <= 1'b1;
                        Busy_TM_Host     <= 1'b1;
                        state            <= LAUNCH;
                    end else if (Start_Host_TM) begin
                        Err_TM_Host <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (last_warp) begin
                        state <= RUN;
                    end else begin
                        counter          <= counter + WARP_ID_W'(1);
                        WarpID_TM_PC     <= counter + WARP_ID_W'(1);
                        StartingPC_TM_PC <= pc_q;
                        UpdatePC_TM_PC   <= 1'b1;
                    end
                end
                RUN: begin
                    if (mask_zero || wdog_fire) begin
                        Busy_TM_Host <= 1'b0;
                        Done_TM_Host <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WARP_LAUNCH_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        timeout_q;

    // A drained mask takes priority: the kernel finished on its own, so no timeout.
    assign wdog_fire = (state == RUN) && !mask_zero &&
                       (wdog_cnt + 16'd1 == 16'(WDOG_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == LAUNCH && last_warp) begin
                wdog_cnt <= '0;
            end else if (state == RUN) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end
            if (wdog_fire) begin
                timeout_q <= 1'b1;
            end else if (accept) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign Timeout_TM_Host = timeout_q;
`else
    assign wdog_fire       = 1'b0;
    assign Timeout_TM_Host = 1'b0;
`endif

endmodule
